// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index, and the writeback entry
// that sits between the writeback producers and the register file write port.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wb_entry_t;

endpackage

// File: rtl/register_file_if.sv
// Write-side bundle of the 32x32 register file: one enable, one select, one data word.
interface register_file_if;
    import cpu_types_pkg::*;

    logic     WEN;
    regbits_t wsel;
    word_t    wdat;

    modport writer (output WEN, wsel, wdat);
    modport array  (input  WEN, wsel, wdat);

endinterface

// File: rtl/regfile_wb_buffer_fwd_match.sv
// Youngest-match lookup over the queued writeback entries for one decode read select.
module wb_fwd_match
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  wb_entry_t [DEPTH-1:0] entries_i,
    input  logic      [DEPTH-1:0] valid_i,
    input  logic      [AW:0]      head_i,
    input  logic      [AW:0]      tail_i,
    input  regbits_t              rsel_i,
    output logic                  hit_o,
    output word_t                 dat_o
);

    // Walk oldest to youngest so the last match standing is the youngest one.
    always_comb begin
        logic [AW:0]   occ;
        logic [AW-1:0] idx;
        hit_o = 1'b0;
        dat_o = '0;
        occ   = tail_i - head_i;
        idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_i[AW-1:0] + AW'(k);
            if (((AW+1)'(k) < occ) && valid_i[idx] && (rsel_i != '0) &&
                (entries_i[idx].wsel == rsel_i)) begin
                hit_o = 1'b1;
                dat_o = entries_i[idx].wdat;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// In-order writeback queue in front of the register file's single write port,
// merging load and ALU writes and forwarding still-queued values to decode.
module regfile_wb_buffer
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          ld_valid,
    input  regbits_t      ld_wsel,
    input  word_t         ld_wdat,
    input  logic          alu_valid,
    input  regbits_t      alu_wsel,
    input  word_t         alu_wdat,
    output logic          ready,
    output logic          overflow,
    output logic [AW:0]   count,
    output logic          rf_WEN,
    output regbits_t      rf_wsel,
    output word_t         rf_wdat,
    input  regbits_t      rsel1,
    input  regbits_t      rsel2,
    output logic          fwd1_hit,
    output word_t         fwd1_dat,
    output logic          fwd2_hit,
    output word_t         fwd2_dat
);

    localparam int unsigned PW = AW + 1;

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic      [DEPTH-1:0] valid_q, valid_d;
    logic      [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic                  overflow_q, overflow_d;

    logic [PW-1:0] count_c;
    logic [PW-1:0] avail_c;
    logic          pop_c, ld_ok_c, alu_ok_c, acc_ld_c, acc_alu_c;

    register_file_if rfif ();

    assign count_c = tail_q - head_q;
    assign pop_c   = (count_c != '0);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            entries_q  <= '0;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    // Pop the head, then append load before ALU; a same-cycle pop frees a slot.
    always_comb begin
        entries_d  = entries_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q;

        ld_ok_c   = ld_valid && (ld_wsel != '0);
        alu_ok_c  = alu_valid && (alu_wsel != '0);
        avail_c   = PW'(DEPTH) - count_c + PW'(pop_c);
        acc_ld_c  = ld_ok_c && (avail_c >= PW'(1));
        acc_alu_c = alu_ok_c && (avail_c >= (acc_ld_c ? PW'(2) : PW'(1)));

        if (pop_c) begin
            valid_d[head_q[AW-1:0]] = 1'b0;
            head_d                  = head_q + PW'(1);
        end
        if (acc_ld_c) begin
            entries_d[tail_d[AW-1:0]].wsel = ld_wsel;
            entries_d[tail_d[AW-1:0]].wdat = ld_wdat;
            valid_d[tail_d[AW-1:0]]        = 1'b1;
            tail_d                         = tail_d + PW'(1);
        end
        if (acc_alu_c) begin
            entries_d[tail_d[AW-1:0]].wsel = alu_wsel;
            entries_d[tail_d[AW-1:0]].wdat = alu_wdat;
            valid_d[tail_d[AW-1:0]]        = 1'b1;
            tail_d                         = tail_d + PW'(1);
        end
        if ((ld_ok_c && !acc_ld_c) || (alu_ok_c && !acc_alu_c)) begin
            overflow_d = 1'b1;
        end
    end

    // Head entry drives the array for the whole cycle; select/data read zero when idle.
    assign rfif.WEN  = pop_c;
    assign rfif.wsel = pop_c ? entries_q[head_q[AW-1:0]].wsel : '0;
    assign rfif.wdat = pop_c ? entries_q[head_q[AW-1:0]].wdat : '0;

    assign rf_WEN   = rfif.WEN;
    assign rf_wsel  = rfif.wsel;
    assign rf_wdat  = rfif.wdat;
    assign count    = count_c;
    assign overflow = overflow_q;
    assign ready    = (count_c <= PW'(DEPTH - 2));

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd1 (
        .entries_i (entries_q),
        .valid_i   (valid_q),
        .head_i    (head_q),
        .tail_i    (tail_q),
        .rsel_i    (rsel1),
        .hit_o     (fwd1_hit),
        .dat_o     (fwd1_dat)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd2 (
        .entries_i (entries_q),
        .valid_i   (valid_q),
        .head_i    (head_q),
        .tail_i    (tail_q),
        .rsel_i    (rsel2),
        .hit_o     (fwd2_hit),
        .dat_o     (fwd2_dat)
    );

endmodule
